histeq_lut_map: RTL and testbench
=================================

# histeq_lut_map

Parametrised histogram-equalisation mapping stage with a double-buffered LUT. It sits after the histogram/CDF accumulator and accepts one cumulative count per grey level in ascending order. It computes the equalisation scale at run time with a sequential divider, then swaps the new LUT in on the next frame start. Streaming pixels are remapped through a fixed-latency pipeline with rounding and saturation.

## Interface
- PIX_W, 8: pixel width; grey levels L = 2^PIX_W
- CNT_W, 20: cumulative-count width
- FRAC_W, 20: fractional bits of scale; SCALE_W = PIX_W+FRAC_W
- clk  in  1  sole clock, rising edge
- rst  in  1  reset; synchronous, active-high
- cdf_level  in  PIX_W  grey level of incoming CDF entry
- cdf_count  in  CNT_W  cumulative pixel count up to cdf_level
- cdf_valid  in  1  entry strobe; accepted only when cdf_ready=1
- cdf_ready  out  1  block accepts CDF entries
- lut_swap_pulse  out  1  one-cycle pulse when the new LUT becomes active
- lut_valid  out  1  a computed LUT is active; 0 = bypass
- per_img_vsync / per_img_href  in  1  input frame/line valid
- per_img_gray  in  PIX_W  input pixel
- post_img_vsync / post_img_href  out  1  syncs delayed by 4
- post_img_gray  out  PIX_W  mapped pixel

## Operation
- Storage: dual-port RAM of depth 2·L, width CNT_W. Address MSB selects the bank. The shadow bank is written and the active bank is read.
- FSM states are IDLE, LOAD, DIV and PEND.
- IDLE: a valid entry with level 0 writes the shadow bank and moves the FSM to LOAD. Non-zero levels are ignored.
- LOAD: each valid entry is written to the shadow bank. A level-0 entry restarts the load and clears the captured minimum. A level-(L-1) entry latches total = cdf_count and moves the FSM to DIV.
- cdf_min: the count of the first entry with cdf_count≠0 in the current load.
- DIV: den = total − cdf_min and num = (L−1)<<FRAC_W. Restoring division, 1 quotient bit per cycle, SCALE_W cycles. If den = 0, scale = 0. The FSM then moves to PEND.
- PEND: waits for a per_img_vsync rising edge (registered previous value 0, current value 1). In that edge cycle the bank select toggles, scale/cdf_min are copied to active registers, lut_valid is set to 1, and lut_swap_pulse is set to 1. The FSM returns to IDLE.
- cdf_ready = 1 in IDLE/LOAD and 0 in DIV/PEND. Entries strobed while cdf_ready = 0 are dropped with no side effect.
- Datapath stages:
  - S1: registered RAM read of the active bank at per_img_gray; gray is also delayed.
  - S2: diff = rd − cdf_min, clamped at 0.
  - S3: prod = diff·scale, CNT_W+SCALE_W bits.
  - S4: out = (prod>>FRAC_W) + prod[FRAC_W−1], saturated to L−1.
- While lut_valid = 0 (bypass), S4 outputs the gray value delayed 4 cycles.
- Pixels are mapped regardless of href; href/vsync are only delayed.

## Timing
- Reset values: cdf_ready 1, lut_valid 0, lut_swap_pulse 0, post_img_vsync/href/gray 0. FSM goes to IDLE; bank 0 is active; scale and cdf_min are 0.
- Latency: per_img_* at cycle t appears as post_img_* at cycle t+4 in every mode.
- Load-to-swap timing:
  - DIV is entered in the cycle after the L−1 write.
  - PEND is entered SCALE_W cycles later.
  - The swap happens on the first vsync rise seen while in PEND; a rise during LOAD/DIV does not swap.
- Pixels sampled in the swap cycle and later use the new bank. Earlier pixels still in the pipeline use the old values, since S2–S4 use values registered alongside their pixel.
- Simultaneous cdf_valid at level L−1 and a vsync rise: no swap; the FSM goes to DIV.
- rst mid-operation: everything returns to reset values and bypass; the RAM contents are don't-care.

## Configuration
- HISTEQ_CDF_MIN_EN:
  - Defined: cdf_min is captured and subtracted (standard equalisation).
  - Undefined: cdf_min is fixed at 0, den = total, and S2 only registers (latency remains 4).

## Structure
- Package histeq_pkg holds:
  - the FSM state enum (IDLE/LOAD/DIV/PEND);
  - the pipeline latency constant PIPE_LAT = 4;
  - width helper functions (SCALE_W, product width).
- Sub-module histeq_scale_div: sequential restoring divider with start/done handshake, num/den in and quotient out, and den=0 → 0.
- The RAM reuses the existing ram_dual_port.

## Test plan
1. Bypass: after reset, no CDF load, gray 0x37 with href → post_img_gray 0x37 four cycles later; lut_valid 0.
2. Linear map (macro on, 640×480): load cdf[k] = (k+1)·1200. Expected scale = 873. After the vsync rise, gray 0 → 0, 127 → 127, 255 → 255; lut_swap_pulse lasts 1 cycle.
3. Swap boundary: finish the load mid-frame → the remaining pixels of that frame are unchanged (bypass/old LUT), and the first pixel after the next vsync rise is remapped.
4. Back-pressure: after the L−1 write, cdf_ready = 0 for SCALE_W cycles plus the PEND wait. Valid entries strobed meanwhile leave the active and shadow results unchanged, and cdf_ready returns to 1 after the swap.
5. Flat image (macro on): cdf[k] = 0 for k < 100 and 307200 for k ≥ 100 → den 0 → gray 100 maps to 0. With the macro off, gray 100 maps to 255.
6. Reset during DIV: one-cycle rst → lut_valid 0, cdf_ready 1, bypass output, no lut_swap_pulse at the next vsync.

Source files
------------

// File: rtl/histeq_lut_map_pkg.sv
// Shared types and width helpers for the histogram-equalisation LUT mapper.
package histeq_pkg;

    typedef enum logic [1:0] {IDLE, LOAD, DIV, PEND} state_t;

    localparam int PIPE_LAT = 4;

    function automatic int scale_w(input int pix_w, input int frac_w);
        return pix_w + frac_w;
    endfunction

    function automatic int prod_w(input int cnt_w, input int sc_w);
        return cnt_w + sc_w;
    endfunction

endpackage

// File: rtl/histeq_scale_div.sv
// Restoring divider, one quotient bit per cycle; a zero divisor yields a zero quotient.
module histeq_scale_div #(
    parameter int NUM_W = 28,
    parameter int DEN_W = 20
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [NUM_W-1:0] num,
    input  logic [DEN_W-1:0] den,
    output logic             done,
    output logic [NUM_W-1:0] quot
);

    localparam int CW = $clog2(NUM_W);
    localparam logic [CW-1:0] LAST = CW'(NUM_W - 1);

    logic             busy;
    logic [CW-1:0]    cnt;
    logic [DEN_W-1:0] den_r, rem;
    logic [NUM_W-1:0] num_sh, q;
    logic             den_zero;
    logic [DEN_W:0]   trial, trial_sub;
    logic             fits;

    // Remainder stays below the divisor, so the shifted trial fits DEN_W+1 bits.
    assign trial     = {rem, num_sh[NUM_W-1]};
    assign trial_sub = trial - {1'b0, den_r};
    assign fits      = trial >= {1'b0, den_r};
    assign done      = busy && (cnt == LAST);
    assign quot      = den_zero ? '0 : q;

    always_ff @(posedge clk) begin
        if (rst) begin
            busy <= 1'b0;
            cnt  <= '0;
        end else if (start) begin
            busy <= 1'b1;
            cnt  <= '0;
        end else if (busy) begin
            cnt <= cnt + 1'b1;
            if (cnt == LAST) busy <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (start) begin
            den_r    <= den;
            den_zero <= (den == '0);
            rem      <= '0;
            num_sh   <= num;
            q        <= '0;
        end else if (busy) begin
            rem    <= fits ? trial_sub[DEN_W-1:0] : trial[DEN_W-1:0];
            num_sh <= num_sh << 1;
            q      <= {q[NUM_W-2:0], fits};
        end
    end

endmodule

// File: rtl/ram_dual_port.sv
// Simple dual-port RAM: one write port, one registered read port, single clock.
module ram_dual_port #(
    parameter int ADDR_W = 9,
    parameter int DATA_W = 20
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [2**ADDR_W];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
        rdata <= mem[raddr];
    end

endmodule

// File: rtl/histeq_lut_map.sv
// Histogram-equalisation mapper: CDF load into shadow bank, scale division, swap on vsync, 4-stage remap.
// Build option HISTEQ_CDF_MIN_EN enables capture and subtraction of the minimum non-zero CDF value.
module histeq_lut_map #(
    parameter int PIX_W  = 8,
    parameter int CNT_W  = 20,
    parameter int FRAC_W = 20
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [PIX_W-1:0] cdf_level,
    input  logic [CNT_W-1:0] cdf_count,
    input  logic             cdf_valid,
    output logic             cdf_ready,
    output logic             lut_swap_pulse,
    output logic             lut_valid,
    input  logic             per_img_vsync,
    input  logic             per_img_href,
    input  logic [PIX_W-1:0] per_img_gray,
    output logic             post_img_vsync,
    output logic             post_img_href,
    output logic [PIX_W-1:0] post_img_gray
);
    import histeq_pkg::*;

    localparam int SCALE_W = scale_w(PIX_W, FRAC_W);
    localparam int PROD_W  = prod_w(CNT_W, SCALE_W);
    localparam int RND_W   = PROD_W - FRAC_W + 1;
    localparam logic [SCALE_W-1:0] DIV_NUM = {{PIX_W{1'b1}}, {FRAC_W{1'b0}}};

    function automatic logic [PIX_W-1:0] round_sat(input logic [PROD_W-1:0] p);
        logic [RND_W-1:0] r;
        r = {1'b0, p[PROD_W-1:FRAC_W]} + RND_W'(p[FRAC_W-1]);
        return (|r[RND_W-1:PIX_W]) ? '1 : r[PIX_W-1:0];
    endfunction

    state_t               state, state_nxt;
    logic                 bank_sel, vs_prev, vs_rise, swap, wr_en, div_start, div_done;
    logic [SCALE_W-1:0]   div_q, scale_act;
    logic [CNT_W-1:0]     den;
    logic [PIPE_LAT-1:0]  vs_dly, hr_dly;

    logic [CNT_W-1:0]     rd_p1;
    logic [PIX_W-1:0]     gray_p1, gray_p2, gray_p3;
    logic [SCALE_W-1:0]   scale_p1, scale_p2;
    logic                 lut_vld_p1, lut_vld_p2, lut_vld_p3;
    logic [CNT_W-1:0]     diff_p2;
    logic [PROD_W-1:0]    prod_p3;

    assign vs_rise   = per_img_vsync & ~vs_prev;
    assign swap      = (state == PEND) && vs_rise;
    assign wr_en     = cdf_valid && cdf_ready && ((state == LOAD) || (cdf_level == '0));
    assign div_start = wr_en && (state == LOAD) && (cdf_level == '1);

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        cdf_ready = 1'b0;
        case (state)
            IDLE: begin
                cdf_ready = 1'b1;
                if (cdf_valid && cdf_level == '0) state_nxt = LOAD;
            end
            LOAD: begin
                cdf_ready = 1'b1;
                if (cdf_valid && cdf_level == '1) state_nxt = DIV;
            end
            DIV:     if (div_done) state_nxt = PEND;
            PEND:    if (vs_rise)  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bank_sel       <= 1'b0;
            vs_prev        <= 1'b0;
            lut_valid      <= 1'b0;
            lut_swap_pulse <= 1'b0;
            scale_act      <= '0;
        end else begin
            vs_prev        <= per_img_vsync;
            lut_swap_pulse <= swap;
            if (swap) begin
                bank_sel  <= ~bank_sel;
                lut_valid <= 1'b1;
                scale_act <= div_q;
            end
        end
    end

`ifdef HISTEQ_CDF_MIN_EN
    function automatic logic [CNT_W-1:0] clamp_diff(input logic [CNT_W-1:0] rd,
                                                    input logic [CNT_W-1:0] mn);
        logic signed [CNT_W:0] d;
        d = $signed({1'b0, rd}) - $signed({1'b0, mn});
        return d[CNT_W] ? '0 : d[CNT_W-1:0];
    endfunction

    logic [CNT_W-1:0] min_sh, min_act, min_p1, min_nxt;
    logic             min_found, found_base;

    // A level-0 entry restarts the search, and may itself be the first non-zero count.
    always_comb begin
        found_base = (cdf_level == '0) ? 1'b0 : min_found;
        min_nxt    = (cdf_level == '0) ? '0 : min_sh;
        if (!found_base && cdf_count != '0) min_nxt = cdf_count;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            min_sh    <= '0;
            min_found <= 1'b0;
            min_act   <= '0;
        end else begin
            if (wr_en) begin
                min_sh    <= min_nxt;
                min_found <= found_base | (cdf_count != '0);
            end
            if (swap) min_act <= min_sh;
        end
    end

    always_ff @(posedge clk) min_p1  <= swap ? min_sh : min_act;
    always_ff @(posedge clk) diff_p2 <= clamp_diff(rd_p1, min_p1);
    assign den = cdf_count - min_nxt;
`else
    always_ff @(posedge clk) diff_p2 <= rd_p1;
    assign den = cdf_count;
`endif

    histeq_scale_div #(.NUM_W(SCALE_W), .DEN_W(CNT_W)) u_div (
        .clk   (clk),
        .rst   (rst),
        .start (div_start),
        .num   (DIV_NUM),
        .den   (den),
        .done  (div_done),
        .quot  (div_q)
    );

    // The swap cycle already reads the new bank, so the bank select is bypassed here.
    ram_dual_port #(.ADDR_W(PIX_W + 1), .DATA_W(CNT_W)) u_ram (
        .clk   (clk),
        .we    (wr_en),
        .waddr ({~bank_sel, cdf_level}),
        .wdata (cdf_count),
        .raddr ({swap ? ~bank_sel : bank_sel, per_img_gray}),
        .rdata (rd_p1)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            vs_dly     <= '0;
            hr_dly     <= '0;
            lut_vld_p1 <= 1'b0;
            lut_vld_p2 <= 1'b0;
            lut_vld_p3 <= 1'b0;
        end else begin
            vs_dly     <= {vs_dly[PIPE_LAT-2:0], per_img_vsync};
            hr_dly     <= {hr_dly[PIPE_LAT-2:0], per_img_href};
            lut_vld_p1 <= lut_valid | swap;
            lut_vld_p2 <= lut_vld_p1;
            lut_vld_p3 <= lut_vld_p2;
        end
    end

    assign post_img_vsync = vs_dly[PIPE_LAT-1];
    assign post_img_href  = hr_dly[PIPE_LAT-1];

    // S1: RAM read in flight, parameters captured alongside the pixel
    always_ff @(posedge clk) begin
        gray_p1  <= per_img_gray;
        scale_p1 <= swap ? div_q : scale_act;
    end

    // S2: offset removal (diff_p2 above), S3: scale multiply
    always_ff @(posedge clk) begin
        gray_p2  <= gray_p1;
        scale_p2 <= scale_p1;
        gray_p3  <= gray_p2;
        prod_p3  <= PROD_W'(diff_p2) * PROD_W'(scale_p2);
    end

    // S4: round, saturate, or pass the delayed gray through in bypass
    always_ff @(posedge clk) begin
        if (rst) post_img_gray <= '0;
        else     post_img_gray <= lut_vld_p3 ? round_sat(prod_p3) : gray_p3;
    end

endmodule

// File: tb/tb_histeq_lut_map.sv
// Scoreboard bench for histeq_lut_map: randomized pixels and CDF loads against a behavioural model.
module tb_histeq_lut_map;

    localparam int L  = 256;
    localparam int SW = 28;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  cdf_level = '0;
    logic [19:0] cdf_count = '0;
    logic        cdf_valid = 1'b0;
    logic        cdf_ready, lut_swap_pulse, lut_valid;
    logic        per_img_vsync = 1'b0, per_img_href = 1'b0;
    logic [7:0]  per_img_gray = '0;
    logic        post_img_vsync, post_img_href;
    logic [7:0]  post_img_gray;

    histeq_lut_map dut (
        .clk(clk), .rst(rst),
        .cdf_level(cdf_level), .cdf_count(cdf_count), .cdf_valid(cdf_valid), .cdf_ready(cdf_ready),
        .lut_swap_pulse(lut_swap_pulse), .lut_valid(lut_valid),
        .per_img_vsync(per_img_vsync), .per_img_href(per_img_href), .per_img_gray(per_img_gray),
        .post_img_vsync(post_img_vsync), .post_img_href(post_img_href), .post_img_gray(post_img_gray)
    );

    always #5 clk = ~clk;

    typedef struct { int t; int vs; int gray; } exp_t;
    exp_t q[$];

    int checks = 0, errors = 0, cyc = 0, pulse_cnt = 0;

    // stimulus for the next cycle
    logic s_vs = 0, s_hr = 0, s_cv = 0, s_rst = 1;
    int   s_lvl = 0, s_cnt = 0, s_gray = 0;

    // reference model state
    longint m_ram [2*L];
    int     m_sel = 0, m_valid = 0, m_busy = 0, m_loading = 0, m_found = 0, m_swaps = 0;
    longint m_min_sh = 0, m_min = 0, m_scale = 0, m_scale_sh = 0, m_min_pend = 0;
    int     m_vs_prev = 0, pend_at = 0;
    int     cdf [L];

    task automatic chk(input string nm, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic int expmap(input int g);
        longint d, p;
        int o;
        if (m_valid == 0) return g;
        d = m_ram[m_sel*L + g] - m_min;
        if (d < 0) d = 0;
        p = d * m_scale;
        o = int'(p / 1048576) + int'((p / 524288) % 2);
        return (o > L-1) ? L-1 : o;
    endfunction

    task automatic tick();
        int rise, acc;
        longint den;
        per_img_vsync = s_vs; per_img_href = s_hr; per_img_gray = 8'(s_gray);
        cdf_valid = s_cv; cdf_level = 8'(s_lvl); cdf_count = 20'(s_cnt); rst = s_rst;
        if (!s_rst) begin
            chk("cdf_ready", cdf_ready, (m_busy == 0));
            chk("lut_valid", lut_valid, m_valid);
        end
        rise = (s_vs && m_vs_prev == 0);
        acc  = (s_cv && m_busy == 0);
        if (s_rst) begin
            m_valid = 0; m_busy = 0; m_loading = 0; m_sel = 0; m_min = 0; m_scale = 0;
        end else begin
            if (m_busy != 0 && rise != 0 && cyc >= pend_at) begin
                m_sel = 1 - m_sel; m_valid = 1; m_busy = 0;
                m_scale = m_scale_sh; m_min = m_min_pend; m_swaps++;
            end
            if (acc != 0) begin
                if (s_lvl == 0) begin m_loading = 1; m_found = 0; m_min_sh = 0; end
                if (m_loading != 0) begin
                    m_ram[(1-m_sel)*L + s_lvl] = s_cnt;
                    if (m_found == 0 && s_cnt != 0) begin m_found = 1; m_min_sh = s_cnt; end
                    if (s_lvl == L-1) begin
`ifdef HISTEQ_CDF_MIN_EN
                        m_min_pend = m_min_sh;
`else
                        m_min_pend = 0;
`endif
                        den = longint'(s_cnt) - m_min_pend;
                        m_scale_sh = (den == 0) ? 0 : (longint'(L-1) * 1048576) / den;
                        m_loading = 0; m_busy = 1; pend_at = cyc + 1 + SW;
                    end
                end
            end
        end
        m_vs_prev = s_rst ? 0 : int'(s_vs);
        if (s_hr && !s_rst) q.push_back('{cyc, int'(s_vs), expmap(s_gray)});
        @(posedge clk);
        #1;
        cyc++;
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (post_img_href) begin
            if (q.size() == 0) chk("sb_underflow", 1, 0);
            else begin
                e = q.pop_front();
                chk("post_gray", post_img_gray, e.gray);
                chk("post_vsync", post_img_vsync, e.vs);
                chk("latency", cyc - e.t, 4);
            end
        end
        if (lut_swap_pulse) pulse_cnt++;
    end

    task automatic rnd_pix();
        s_hr = ($urandom_range(0, 3) != 0);
        s_gray = $urandom_range(0, L-1);
    endtask

    task automatic run(input int n, input int strobes);
        for (int i = 0; i < n; i++) begin
            rnd_pix();
            s_cv = (strobes != 0) && ($urandom_range(0, 1) != 0);
            s_lvl = ($urandom_range(0, 1) != 0) ? 0 : L-1;
            s_cnt = $urandom_range(0, 1000000);
            tick();
        end
        s_cv = 0;
    endtask

    task automatic pix(input int g, input logic vs);
        s_vs = vs; s_hr = 1; s_gray = g; s_cv = 0;
        tick();
    endtask

    task automatic quiet(input int n);
        s_hr = 0; s_cv = 0;
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic load_cdf();
        for (int k = 0; k < L; k++) begin
            if ($urandom_range(0, 9) == 0) begin s_cv = 0; rnd_pix(); tick(); end
            s_cv = 1; s_lvl = k; s_cnt = cdf[k]; rnd_pix(); tick();
        end
        s_cv = 0;
    endtask

    task automatic make_rand_cdf();
        int acc = 0;
        int z = $urandom_range(0, 30);
        for (int k = 0; k < L; k++) begin
            if (k >= z) acc += $urandom_range(0, 2000);
            cdf[k] = acc;
        end
    endtask

    initial begin
        foreach (m_ram[i]) m_ram[i] = 0;
        s_rst = 1; tick(); tick();
        s_rst = 0;
        chk("rst_cdf_ready", cdf_ready, 1);
        chk("rst_lut_valid", lut_valid, 0);
        chk("rst_swap_pulse", lut_swap_pulse, 0);
        chk("rst_post_vsync", post_img_vsync, 0);
        chk("rst_post_href", post_img_href, 0);
        chk("rst_post_gray", post_img_gray, 0);

        // bypass
        pix(8'h37, 0);
        run(10, 0);

        // linear map, vsync rise during DIV ignored, strobes while busy dropped
        s_vs = 0;
        for (int k = 0; k < L; k++) cdf[k] = (k + 1) * 1200;
        load_cdf();
        run(5, 1);
        s_vs = 1; run(8, 1);
        s_vs = 0; run(30, 1);
        pix(0, 1); pix(127, 1); pix(255, 1);
        run(20, 0);
        s_vs = 0; run(5, 0);

        // load completes mid-frame; swap at the following frame start
        s_vs = 1; run(3, 0);
        make_rand_cdf();
        load_cdf();
        run(40, 0);
        s_vs = 0; run(3, 0);
        pix($urandom_range(0, L-1), 1);
        run(20, 0);
        s_vs = 0; run(3, 0);

        // flat image
        for (int k = 0; k < L; k++) cdf[k] = (k < 100) ? 0 : 307200;
        load_cdf();
        run(40, 0);
        pix(100, 1); pix(99, 1); pix(200, 1);
        run(5, 0);
        s_vs = 0; run(3, 0);

        // random loads
        for (int r = 0; r < 2; r++) begin
            make_rand_cdf();
            load_cdf();
            run(35, 1);
            s_vs = 1; run(30, 0);
            s_vs = 0; run(3, 0);
        end

        // reset during DIV
        make_rand_cdf();
        load_cdf();
        quiet(6);
        s_rst = 1; tick();
        s_rst = 0;
        chk("div_rst_lut_valid", lut_valid, 0);
        chk("div_rst_cdf_ready", cdf_ready, 1);
        run(40, 0);
        s_vs = 1; run(20, 0);
        s_vs = 0; run(3, 0);

        quiet(8);
        chk("sb_drain", q.size(), 0);
        chk("swap_pulses", pulse_cnt, m_swaps);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
